// File: rtl/lc3_int_arbiter.sv
// LC-3 interrupt arbiter: latches device request edges and picks the highest-priority enabled source.
// Raises INT when that source outranks PSR[10:8]. Define INT_SYNC_EN to add a 2-flop irq synchronizer.
module lc3_int_arbiter #(
   parameter int unsigned          NUM_SRC    = 4,
   parameter logic [7:0]           VEC_BASE   = 8'h80,
   parameter logic [3*NUM_SRC-1:0] PRIO_TABLE = 12'h444
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq,
   input  logic [NUM_SRC-1:0] ie,
   input  logic [2:0]         psr_pl,
   input  logic               int_ack,
   output logic               INT,
   output logic [7:0]         INTV,
   output logic [2:0]         int_pl,
   output logic [NUM_SRC-1:0] pending
);
   localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] irq_s;
   logic [NUM_SRC-1:0] irq_q, irq_prev_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] cand;
   logic [IdxW-1:0]    gidx_q, gidx_d;
   logic [7:0]         intv_q, intv_d;
   logic [2:0]         pl_q, pl_d;
   logic               win_vld;
   logic [IdxW-1:0]    win_idx;
   logic [2:0]         win_pl;

`ifdef INT_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq;
`endif

   // Sample, then compare against the previous sample: a rise sampled at edge N lands at N+1.
   assign rise = irq_q & ~irq_prev_q;
   assign cand = pending_q & ie;

   // Strict '>' keeps the lowest index on equal priorities.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_pl  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cand[i] && (!win_vld || PRIO_TABLE[3*i +: 3] > win_pl)) begin
            win_vld = 1'b1;
            win_idx = IdxW'(i);
            win_pl  = PRIO_TABLE[3*i +: 3];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      intv_d  = intv_q;
      pl_d    = pl_q;
      clr     = '0;
      unique case (state_q)
         StIdle: begin
            if (win_vld && (win_pl > psr_pl)) begin
               state_d = StReq;
               gidx_d  = win_idx;
               intv_d  = VEC_BASE + 8'(win_idx);
               pl_d    = win_pl;
            end
         end
         StReq: begin
            // The grant is frozen; only ack or loss of eligibility ends it.
            if (int_ack) begin
               clr[gidx_q] = 1'b1;
               state_d     = StDone;
            end else if (!ie[gidx_q] || (pl_q <= psr_pl)) begin
               state_d = StIdle;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A fresh edge in the ack cycle wins over the clear.
   assign pending_d = (pending_q & ~clr) | rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         irq_q      <= '0;
         irq_prev_q <= '0;
         pending_q  <= '0;
         gidx_q     <= '0;
         intv_q     <= 8'h00;
         pl_q       <= 3'b000;
      end else begin
         state_q    <= state_d;
         irq_q      <= irq_s;
         irq_prev_q <= irq_q;
         pending_q  <= pending_d;
         gidx_q     <= gidx_d;
         intv_q     <= intv_d;
         pl_q       <= pl_d;
      end
   end

   assign INT     = (state_q == StReq);
   assign INTV    = intv_q;
   assign int_pl  = pl_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_lc3_int_arbiter.sv
// Bench for lc3_int_arbiter: directed scenarios plus random traffic, all compared every cycle
// against a behavioural model of request latching, arbitration and grant handshake.
module tb_lc3_int_arbiter;
   // Packed 3 bits per source: src0=2, src1=5, src2=1, src3=5 (src1/src3 tie).
   localparam logic [11:0] PRIO = 12'hA6A;
`ifdef INT_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] irq = '0;
   logic [3:0] ie = '0;
   logic [2:0] psr_pl = '0;
   logic       int_ack = 1'b0;
   logic       INT;
   logic [7:0] INTV;
   logic [2:0] int_pl;
   logic [3:0] pending;

   lc3_int_arbiter #(
      .NUM_SRC   (4),
      .VEC_BASE  (8'h80),
      .PRIO_TABLE(PRIO)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .irq    (irq),
      .ie     (ie),
      .psr_pl (psr_pl),
      .int_ack(int_ack),
      .INT    (INT),
      .INTV   (INTV),
      .int_pl (int_pl),
      .pending(pending)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model: irq sample history (newest first), pending set, and grant bookkeeping.
   logic [3:0] hist[$];
   logic [3:0] m_pend;
   bit         m_busy;
   bit         m_cool;
   int         m_src;
   logic [7:0] m_vec;
   logic [2:0] m_pl;

   function automatic int prio(input int i);
      return int'((PRIO >> (3 * i)) & 12'd7);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_front(4'b0000);
      m_pend = '0;
      m_busy = 1'b0;
      m_cool = 1'b0;
      m_src  = 0;
      m_vec  = 8'h00;
      m_pl   = 3'b000;
   endtask

   task automatic model_step();
      logic [3:0] rise;
      logic [3:0] clr;
      int         best;
      rise = hist[LAT-2] & ~hist[LAT-1];
      clr  = '0;
      if (m_busy) begin
         if (int_ack) begin
            clr[m_src] = 1'b1;
            m_busy     = 1'b0;
            m_cool     = 1'b1;
         end else if (!ie[m_src] || (int'(m_pl) <= int'(psr_pl))) begin
            m_busy = 1'b0;
         end
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else begin
         best = -1;
         for (int i = 0; i < 4; i++)
            if (m_pend[i] && ie[i] && (best < 0 || prio(i) > prio(best))) best = i;
         if (best >= 0 && prio(best) > int'(psr_pl)) begin
            m_busy = 1'b1;
            m_src  = best;
            m_vec  = 8'(128 + best);
            m_pl   = 3'(prio(best));
         end
      end
      m_pend = (m_pend & ~clr) | rise;
      hist.push_front(irq);
      void'(hist.pop_back());
   endtask

   // One clock: advance the model with the current inputs, then compare just after the edge.
   task automatic cyc();
      if (reset) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      chk("INT", 32'(INT), 32'(m_busy));
      chk("INTV", 32'(INTV), 32'(m_vec));
      chk("int_pl", 32'(int_pl), 32'(m_pl));
      chk("pending", 32'(pending), 32'(m_pend));
   endtask

   task automatic wait_int(input string name);
      int n;
      n = 0;
      while (INT !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk(name, 32'(INT), 1);
   endtask

   task automatic ack();
      int_ack = 1'b1;
      cyc();
      int_ack = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] v);
      irq = v;
      cyc();
      irq = '0;
   endtask

   initial begin
      int n;
      model_reset();
      #2;
      chk("rst INT", 32'(INT), 0);
      chk("rst INTV", 32'(INTV), 0);
      chk("rst int_pl", 32'(int_pl), 0);
      chk("rst pending", 32'(pending), 0);
      repeat (2) cyc();
      reset = 1'b0;
      repeat (2) cyc();

      // Single source latency and ack handshake.
      ie = 4'b0001;
      psr_pl = 3'd0;
      pulse(4'b0001);
      n = 0;
      while (INT !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk("latency", 32'(n), 32'(LAT));
      chk("single INTV", 32'(INTV), 32'h80);
      chk("single int_pl", 32'(int_pl), 2);
      ack();
      chk("ack INT", 32'(INT), 0);
      chk("ack pending", 32'(pending), 0);
      repeat (3) cyc();
      chk("after done INT", 32'(INT), 0);

      // Equal priority is masked; lowering psr_pl releases it.
      psr_pl = 3'd2;
      pulse(4'b0001);
      repeat (LAT + 3) cyc();
      chk("masked INT", 32'(INT), 0);
      chk("masked pending", 32'(pending), 1);
      psr_pl = 3'd1;
      cyc();
      chk("unmask INT", 32'(INT), 1);
      chk("unmask INTV", 32'(INTV), 32'h80);
      ack();
      psr_pl = 3'd0;
      cyc();

      // Arbitration order, then tie on equal priorities.
      ie = 4'b0111;
      pulse(4'b0111);
      wait_int("arb1 INT");
      chk("arb1 INTV", 32'(INTV), 32'h81);
      chk("arb1 int_pl", 32'(int_pl), 5);
      ack();
      wait_int("arb2 INT");
      chk("arb2 INTV", 32'(INTV), 32'h80);
      chk("arb2 int_pl", 32'(int_pl), 2);
      ack();
      wait_int("arb3 INT");
      chk("arb3 INTV", 32'(INTV), 32'h82);
      chk("arb3 int_pl", 32'(int_pl), 1);
      ack();
      ie = 4'b1010;
      pulse(4'b1010);
      wait_int("tie INT");
      chk("tie INTV", 32'(INTV), 32'h81);
      ack();
      wait_int("tie2 INT");
      chk("tie2 INTV", 32'(INTV), 32'h83);
      ack();
      cyc();

      // New edge on the granted source in the ack cycle keeps it pending.
      ie = 4'b0001;
      pulse(4'b0001);
      wait_int("coll INT");
      irq = 4'b0001;
      repeat (LAT - 1) cyc();
      ack();
      irq = '0;
      chk("coll pending", 32'(pending), 1);
      chk("coll INT", 32'(INT), 0);
      wait_int("coll reraise");
      ack();
      cyc();

      // Withdraw on psr_pl raise, resume afterwards.
      pulse(4'b0001);
      wait_int("wd INT");
      psr_pl = 3'd7;
      cyc();
      chk("wd INT", 32'(INT), 0);
      chk("wd pending", 32'(pending), 1);
      psr_pl = 3'd0;
      wait_int("wd resume");
      ack();
      cyc();

      // Higher-priority arrival does not preempt the current grant.
      ie = 4'b0110;
      pulse(4'b0100);
      wait_int("np INT");
      pulse(4'b0010);
      repeat (LAT + 2) cyc();
      chk("np INTV", 32'(INTV), 32'h82);
      chk("np pending", 32'(pending), 32'h6);
      ack();
      wait_int("np next");
      chk("np next INTV", 32'(INTV), 32'h81);
      ack();
      cyc();

      // Ack outside a grant is ignored.
      ie = 4'b0000;
      pulse(4'b0001);
      repeat (LAT + 1) cyc();
      ack();
      cyc();
      chk("stray ack pending", 32'(pending), 1);
      ie = 4'b0001;
      wait_int("stray resume");

      // Async reset mid-grant clears outputs with no clock edge.
      reset = 1'b1;
      #1;
      chk("async INT", 32'(INT), 0);
      chk("async INTV", 32'(INTV), 0);
      chk("async int_pl", 32'(int_pl), 0);
      chk("async pending", 32'(pending), 0);
      cyc();
      reset = 1'b0;
      cyc();

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         irq = 4'($urandom) & 4'($urandom);
         ie = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         if ($urandom_range(0, 15) == 0) psr_pl = 3'($urandom_range(0, 5));
         int_ack = INT ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 499) == 0);
         cyc();
      end
      reset = 1'b0;
      int_ack = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
